// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock, ready/valid handshakes on both sides.
// Ports:
//   clk, reset_n           - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready, a, b, carryin      - operand word handshake, sampled on acceptance
//   out_valid/out_ready, sum, carryout, overflow - result handshake, held until taken
//   busy                   - high while bits are being shifted through the adder
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c, last;

    assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
    assign fa_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign last = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                c_d     = carryin;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_c;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // Visible outputs change only when the full word is complete;
                // c_q here is the carry into the MSB, giving signed overflow.
                if (last) begin
                    state_d = DONE;
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    ovf_d   = c_q ^ fa_c;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q == SHIFT;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign carryout  = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and exhaustive checks of serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv8 = 0, or8 = 0, ci8 = 0;
    logic [7:0] a8 = 0, b8 = 0;
    logic       ir8, ov8, co8, of8, bz8;
    logic [7:0] s8;

    logic       iv4 = 0, or4 = 0, ci4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic       ir4, ov4, co4, of4, bz4;
    logic [3:0] s4;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .carryin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .carryout(co8),
        .overflow(of8), .busy(bz8)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .carryin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .carryout(co4),
        .overflow(of4), .busy(bz4)
    );

    // Present one word, then scramble the operand pins to show they are not resampled.
    // lat counts rising edges after the acceptance edge until out_valid is seen.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ci, output int lat);
        @(negedge clk);
        a8 = x; b8 = y; ci8 = ci; iv8 = 1;
        @(negedge clk);
        iv8 = 0; a8 = 8'hC3; b8 = 8'h3C; ci8 = ~ci;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic ci, output int lat);
        @(negedge clk);
        a4 = x; b4 = y; ci4 = ci; iv4 = 1;
        @(negedge clk);
        iv4 = 0; a4 = ~x; b4 = ~y; ci4 = ~ci;
        lat = 0;
        while (ov4 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", ir8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov8); end
        checks++; if (bz8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bz8); end
        checks++; if ({co8, of8, s8} !== 10'h0) begin errors++; $display("FAIL reset_outputs got %h exp 000", {co8, of8, s8}); end
        reset_n = 1;
    endtask

    task automatic test_add8;
        logic [7:0] va [5] = '{8'h00, 8'hFF, 8'h7F, 8'hA5, 8'h80};
        logic [7:0] vb [5] = '{8'h00, 8'h01, 8'h01, 8'h5A, 8'h80};
        logic       vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] es [5] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00};
        logic       eco [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       eov [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            run8(va[i], vb[i], vc[i], lat);
            checks++; if (lat !== 8) begin errors++; $display("FAIL add8_latency[%0d] got %0d exp 8", i, lat); end
            checks++; if (s8 !== es[i]) begin errors++; $display("FAIL add8_sum[%0d] got %h exp %h", i, s8, es[i]); end
            checks++; if (co8 !== eco[i]) begin errors++; $display("FAIL add8_carry[%0d] got %b exp %b", i, co8, eco[i]); end
            checks++; if (of8 !== eov[i]) begin errors++; $display("FAIL add8_overflow[%0d] got %b exp %b", i, of8, eov[i]); end
            or8 = 1;
            @(negedge clk);
            or8 = 0;
            checks++; if ({ir8, ov8} !== 2'b10) begin errors++; $display("FAIL add8_release[%0d] got %b exp 10", i, {ir8, ov8}); end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        run8(8'h10, 8'h20, 1'b0, lat);
        checks++; if (s8 !== 8'h30) begin errors++; $display("FAIL bp_first_sum got %h exp 30", s8); end
        a8 = 8'h11; b8 = 8'h22; ci8 = 0; iv8 = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({ov8, ir8, bz8, co8, of8, s8} !== {5'b10000, 8'h30}) begin
                errors++; $display("FAIL bp_hold[%0d] got %b exp 1000000110000", i, {ov8, ir8, bz8, co8, of8, s8});
            end
        end
        or8 = 1;
        @(negedge clk);
        or8 = 0;
        checks++; if ({ir8, ov8, bz8} !== 3'b100) begin errors++; $display("FAIL bp_idle got %b exp 100", {ir8, ov8, bz8}); end
        @(negedge clk);
        iv8 = 0;
        checks++; if (bz8 !== 1'b1) begin errors++; $display("FAIL bp_accept_busy got %b exp 1", bz8); end
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency got %0d exp 8", lat); end
        checks++; if (s8 !== 8'h33) begin errors++; $display("FAIL bp_second_sum got %h exp 33", s8); end
        or8 = 1;
        @(negedge clk);
        or8 = 0;
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; ci8 = 0; iv8 = 1;
        @(negedge clk);
        iv8 = 0;
        repeat (3) @(negedge clk);
        checks++; if (bz8 !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", bz8); end
        reset_n = 0;
        #1;
        checks++; if ({ov8, bz8, ir8} !== 3'b001) begin errors++; $display("FAIL mid_reset_flags got %b exp 001", {ov8, bz8, ir8}); end
        checks++; if ({co8, of8, s8} !== 10'h0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 000", {co8, of8, s8}); end
        @(negedge clk);
        reset_n = 1; a8 = 8'h03; b8 = 8'h04; ci8 = 0; iv8 = 1;
        @(negedge clk);
        iv8 = 0;
        checks++; if (bz8 !== 1'b1) begin errors++; $display("FAIL mid_first_edge_accept got %b exp 1", bz8); end
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL mid_latency got %0d exp 8", lat); end
        checks++; if ({co8, of8, s8} !== {2'b00, 8'h07}) begin errors++; $display("FAIL mid_fresh_sum got %h exp 007", {co8, of8, s8}); end
        or8 = 1;
        @(negedge clk);
        or8 = 0;
    endtask

    task automatic test_exhaustive4;
        int lat, r, sr;
        logic [4:0] ex;
        logic eo;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    run4(4'(x), 4'(y), 1'(c), lat);
                    r  = x + y + c;
                    ex = 5'(r);
                    sr = (x > 7 ? x - 16 : x) + (y > 7 ? y - 16 : y) + c;
                    eo = (sr > 7) || (sr < -8);
                    checks++; if ({co4, s4} !== ex || of4 !== eo || lat !== 4) begin
                        errors++;
                        $display("FAIL ex4 a=%h b=%h c=%0d got co,sum=%h ovf=%b lat=%0d exp %h %b 4", x, y, c, {co4, s4}, of4, lat, ex, eo);
                    end
                    or4 = 1;
                    @(negedge clk);
                    or4 = 0;
                end
    endtask

    initial begin
        test_reset;
        test_add8;
        test_backpressure;
        test_reset_mid;
        test_exhaustive4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand word presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand word.
REQ-006 SHALL have port a, input, WIDTH, first operand.
REQ-007 SHALL have port b, input, WIDTH, second operand.
REQ-008 SHALL have port carryin, input, 1, carry into bit 0.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port sum, output, WIDTH, a+b+carryin modulo 2^WIDTH.
REQ-012 SHALL have port carryout, output, 1, carry out of bit WIDTH-1.
REQ-013 SHALL have port overflow, output, 1, two's-complement signed overflow.
REQ-014 SHALL have port busy, output, 1, high while bits are being processed.

Function
REQ-015 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; busy=1 only in SHIFT; out_valid=1 only in DONE.
REQ-017 SHALL, on a rising edge with in_valid=1 and in_ready=1, load a and b into shift registers, load the carry register with carryin, clear the bit counter, and enter SHIFT.
REQ-018 SHALL sample a, b and carryin only on the acceptance edge; later changes to them have no effect.
REQ-019 SHALL, in each SHIFT cycle, apply a one-bit full-adder function to the LSBs of the two operand shift registers and the carry register, shift the sum bit into the result register from the MSB end, shift both operand registers right by one, update the carry register, and increment the counter.
REQ-020 SHALL process bit 0 first; after exactly WIDTH SHIFT cycles the result register holds sum with bit 0 in position 0.
REQ-021 SHALL record the carry into bit WIDTH-1 during the final SHIFT cycle and compute overflow as that carry XOR the final carry out.
REQ-022 SHALL transition SHIFT->DONE on the edge that processes bit WIDTH-1; out_valid rises WIDTH cycles after the acceptance edge.
REQ-023 SHALL hold sum, carryout and overflow stable in DONE until an edge with out_ready=1, then return to IDLE.
REQ-024 SHALL NOT accept a new word in the DONE->IDLE cycle; minimum spacing between acceptances is WIDTH+2 cycles.
REQ-025 SHALL ignore in_valid in SHIFT and DONE (no queuing, no state change).
REQ-026 SHALL ignore out_ready outside DONE.
REQ-027 SHALL keep sum, carryout and overflow at their last result values in IDLE and SHIFT; they are meaningful only while out_valid=1.
REQ-028 SHALL use a counter of ceil(log2(WIDTH))+1 bits; it shall never wrap within a transaction.

Reset
REQ-029 SHALL, while reset_n=0, immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carryout=0, overflow=0, counter=0, and all shift/carry registers to 0.
REQ-030 SHALL abort any in-progress transaction on reset assertion with no partial result emitted.
REQ-031 SHALL accept a word on the first rising edge after reset_n deasserts if in_valid=1.

Verification
REQ-032 WIDTH=8: a=8'h00, b=8'h00, carryin=0 -> after 8 cycles out_valid=1, sum=8'h00, carryout=0, overflow=0.
REQ-033 WIDTH=8: a=8'hFF, b=8'h01, carryin=0 -> sum=8'h00, carryout=1, overflow=0; a=8'h7F, b=8'h01 -> sum=8'h80, carryout=0, overflow=1.
REQ-034 WIDTH=8: a=8'hA5, b=8'h5A, carryin=1 -> sum=8'h00, carryout=1, overflow=0; a=8'h80, b=8'h80, carryin=0 -> sum=8'h00, carryout=1, overflow=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0; after out_ready=1 the next word is accepted on the following edge.
REQ-036 Reset mid-op: assert reset_n=0 after 3 SHIFT cycles -> in the same cycle out_valid=0, busy=0, sum=0; after release in_ready=1 and a fresh 8'h03+8'h04 gives sum=8'h07.
REQ-037 Exhaustive: for WIDTH=4 all 512 (a,b,carryin) combinations -> {carryout,sum} equals a+b+carryin and overflow matches the signed reference.
